seg_scan: RTL and testbench
===========================

Name: seg_scan

Overview:
- Consumer end of the 20-bit `disp` bus: four 5-bit character codes, with `disp[19:15]` as the leftmost digit.
- Time-multiplexes the four codes onto a common-anode 4-digit 7-segment display.
- Adds the following, so producers only ever drive static character codes:
  - frame-coherent snapshotting
  - anti-ghosting dead time
  - per-digit blinking
  - decimal-point passthrough

Parameters:
- DIV, 50000: clock cycles per digit slot (must be >= DEAD+2).
- DEAD, 500: cycles at the start of each slot with all anodes off (must be >= 1).
- BLINK_DIV, 125: frames per blink half-period (must be >= 1).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-low.
- disp  in  20  four character codes: [19:15] digit 3 (leftmost) … [4:0] digit 0.
- blink  in  4  bit i=1 makes digit i blink.
- dp_in  in  4  bit i=1 lights the decimal point of digit i.
- an  out  4  anode enables, active-low, an[i] drives digit i.
- seg  out  7  segments {g,f,e,d,c,b,a}, active-low.
- dp  out  1  decimal point, active-low.
- frame_tick  out  1  one-cycle pulse when a new frame snapshot is taken.

Behaviour:
- Reset (rst=0, asynchronous): all counters are 0 and the blink phase is 0. The snapshot holds {31,31,31,31} (all blank). Outputs are an=4'b1111, seg=7'h7F, dp=1, frame_tick=0.
- Prescaler `pcnt` counts 0..DIV-1 and wraps. At wrap, `slot` advances 3→2→1→0→3. The scan order is leftmost first, and `slot` resets to 3.
- Snapshot: when pcnt==0 and slot==3, the following are registered into frame registers:
  - `disp`
  - `blink`
  - `dp_in`
  On that same cycle frame_tick=1. Inputs are ignored mid-frame, so a change never tears a frame.
- Blink phase: a frame counter counts snapshots 0..BLINK_DIV-1. At its wrap, `bphase` toggles.
- Digit enable: `en = (pcnt >= DEAD) && !(bphase && frame_blink[slot])`.
- All outputs are registered and appear one cycle after the counter state that produced them:
  - `an` = en ? ~(4'b1 << slot) : 4'b1111.
  - `seg` = en ? decode(frame_disp[slot]) : 7'h7F.
  - `dp` = en ? ~frame_dp[slot] : 1.
- Decode table, codes to {g..a} active-low:
  - 0 → 1000000
  - 1 → 1111001
  - 2 → 0100100
  - 3 → 0110000
  - 4 → 0011001
  - 5 → 0010010
  - 6 → 0000010
  - 7 → 1111000
  - 8 → 0000000
  - 9 → 0010000
  - 10 A → 0001000
  - 11 b → 0000011
  - 12 C → 1000110
  - 13 d → 0100001
  - 14 E → 0000110
  - 15 F → 0001110
  - 16 H → 0001001
  - 17 L → 1000111
  - 18 P → 0001100
  - 19 n → 0101011
  - 20 o → 0100011
  - 21 U → 1000001
  - 22 '-' → 0111111
  - 23 '_' → 1110111
  - 24 t → 0000111
  - 25 r → 0101111
  - 26 y → 0010001
  - 27–30 reserved → blank
  - 31 blank → 1111111
- At most one an bit is low in any cycle. During dead time, an=4'b1111.
- Reset asserted mid-slot returns all state to the reset values immediately. The first frame after release shows the new `disp`: the snapshot is taken on the first rising edge with rst=1.
- A blink bit for a digit whose code is 31 has no visible effect; the digit stays dark.

Decomposition:
- Shared package `seg_pkg` holds:
  - character-code constants: CH_0..CH_9, CH_A..CH_F, CH_H=16, CH_L=17, CH_P=18, CH_N=19, CH_O=20, CH_U=21, CH_DASH=22, CH_UNDER=23, CH_T=24, CH_R=25, CH_Y=26, CH_BLANK=31
  - SEG_OFF=7'h7F
- The "Err" message used upstream is {CH_BLANK,CH_E,CH_R,CH_R}.
- One sub-module, `seg_decode`: combinational 5-bit code → 7-bit active-low pattern, per the table above.

Test Plan (DIV=8, DEAD=2, BLINK_DIV=2):
- Reset release with disp={1,2,3,4}:
  - frame_tick=1 on the first edge.
  - an=1111 for 2 slot cycles, then an=0111 with seg=1111001 for 6 cycles.
  - Then digit 2 (an=1011) shows seg=0100100, then 3 (0110000), then 4 (0011001).
  - frame_tick repeats every 32 cycles.
- Change disp to {31,14,25,25} mid-frame at cycle 12:
  - The current frame still shows {1,2,3,4}.
  - At cycle 32, frame_tick fires and the next frame shows an=0111 seg=7F, then E=0000110, r=0101111, r=0101111.
- blink=4'b0001:
  - Digit 0 is lit in frames 0–1, dark (an=1111 in slot 0) in frames 2–3, and lit again in frames 4–5.
  - The other digits are unaffected.
- dp_in=4'b0100: dp=0 only while an=1011 outside dead time; otherwise dp=1.
- Drop rst in the middle of slot 2:
  - Outputs go to an=1111, seg=7F, dp=1 in the same cycle, without waiting for a clock.
  - After release, scanning restarts at slot 3 with a fresh snapshot.
- Every cycle, assert popcount(~an) <= 1. Also assert that an==1111 whenever pcnt<DEAD, counting the register delay.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared character codes and helpers for the 4-digit 7-segment scanner.
// Pure definitions, no latency; no flow control involved.
package seg_pkg;

    typedef logic [4:0] char_t;
    typedef logic [6:0] seg_t;

    localparam char_t CH_0     = 5'd0;
    localparam char_t CH_1     = 5'd1;
    localparam char_t CH_2     = 5'd2;
    localparam char_t CH_3     = 5'd3;
    localparam char_t CH_4     = 5'd4;
    localparam char_t CH_5     = 5'd5;
    localparam char_t CH_6     = 5'd6;
    localparam char_t CH_7     = 5'd7;
    localparam char_t CH_8     = 5'd8;
    localparam char_t CH_9     = 5'd9;
    localparam char_t CH_A     = 5'd10;
    localparam char_t CH_B     = 5'd11;
    localparam char_t CH_C     = 5'd12;
    localparam char_t CH_D     = 5'd13;
    localparam char_t CH_E     = 5'd14;
    localparam char_t CH_F     = 5'd15;
    localparam char_t CH_H     = 5'd16;
    localparam char_t CH_L     = 5'd17;
    localparam char_t CH_P     = 5'd18;
    localparam char_t CH_N     = 5'd19;
    localparam char_t CH_O     = 5'd20;
    localparam char_t CH_U     = 5'd21;
    localparam char_t CH_DASH  = 5'd22;
    localparam char_t CH_UNDER = 5'd23;
    localparam char_t CH_T     = 5'd24;
    localparam char_t CH_R     = 5'd25;
    localparam char_t CH_Y     = 5'd26;
    localparam char_t CH_BLANK = 5'd31;

    localparam seg_t SEG_OFF = 7'h7F;

    // Message producers drive when something upstream goes wrong.
    localparam logic [19:0] MSG_ERR = {CH_BLANK, CH_E, CH_R, CH_R};

    // Everything latched at the start of a frame, so a frame never tears.
    typedef struct packed {
        logic [19:0] disp;
        logic [3:0]  blink;
        logic [3:0]  dp;
    } frame_t;

    localparam frame_t FRAME_RST = '{disp: {4{CH_BLANK}}, blink: 4'b0000, dp: 4'b0000};

    function automatic char_t char_at(input logic [19:0] d, input logic [1:0] s);
        char_t r;
        case (s)
            2'd0:    r = d[4:0];
            2'd1:    r = d[9:5];
            2'd2:    r = d[14:10];
            default: r = d[19:15];
        endcase
        return r;
    endfunction

endpackage

// File: rtl/seg_decode.sv
// Character code to active-low {g,f,e,d,c,b,a} segment pattern.
// Combinational, zero latency; no flow control.
module seg_decode
    import seg_pkg::*;
(
    input  char_t code_i,
    output seg_t  seg_o
);

    always_comb begin
        seg_o = SEG_OFF;
        case (code_i)
            CH_0:     seg_o = 7'b1000000;
            CH_1:     seg_o = 7'b1111001;
            CH_2:     seg_o = 7'b0100100;
            CH_3:     seg_o = 7'b0110000;
            CH_4:     seg_o = 7'b0011001;
            CH_5:     seg_o = 7'b0010010;
            CH_6:     seg_o = 7'b0000010;
            CH_7:     seg_o = 7'b1111000;
            CH_8:     seg_o = 7'b0000000;
            CH_9:     seg_o = 7'b0010000;
            CH_A:     seg_o = 7'b0001000;
            CH_B:     seg_o = 7'b0000011;
            CH_C:     seg_o = 7'b1000110;
            CH_D:     seg_o = 7'b0100001;
            CH_E:     seg_o = 7'b0000110;
            CH_F:     seg_o = 7'b0001110;
            CH_H:     seg_o = 7'b0001001;
            CH_L:     seg_o = 7'b1000111;
            CH_P:     seg_o = 7'b0001100;
            CH_N:     seg_o = 7'b0101011;
            CH_O:     seg_o = 7'b0100011;
            CH_U:     seg_o = 7'b1000001;
            CH_DASH:  seg_o = 7'b0111111;
            CH_UNDER: seg_o = 7'b1110111;
            CH_T:     seg_o = 7'b0000111;
            CH_R:     seg_o = 7'b0101111;
            CH_Y:     seg_o = 7'b0010001;
            default:  seg_o = SEG_OFF;
        endcase
    end

endmodule

// File: rtl/seg_scan.sv
// Scans four frame-coherent character codes onto a common-anode 4-digit display.
// Outputs registered, one cycle behind the scan counters; no backpressure, display free-runs.
module seg_scan
    import seg_pkg::*;
#(
    parameter int unsigned DIV       = 50000,
    parameter int unsigned DEAD      = 500,
    parameter int unsigned BLINK_DIV = 125
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [19:0] disp,
    input  logic [3:0]  blink,
    input  logic [3:0]  dp_in,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        frame_tick
);

    localparam int unsigned PW = (DIV > 2) ? $clog2(DIV) : 1;
    localparam int unsigned BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [PW-1:0] PCNT_LAST = PW'(DIV - 1);
    localparam logic [PW-1:0] DEAD_C    = PW'(DEAD);
    localparam logic [BW-1:0] FCNT_LAST = BW'(BLINK_DIV - 1);

    logic [PW-1:0] pcnt_q, pcnt_d;
    logic [1:0]    slot_q, slot_d;
    logic [BW-1:0] fcnt_q, fcnt_d;
    logic          bphase_q, bphase_d;
    frame_t        frame_q, frame_d;

    logic [3:0]    an_d;
    seg_t          seg_d;
    logic          dp_d;
    logic          tick_d;

    logic          slot_end;
    logic          frame_start;
    logic          frame_end;
    logic          en;
    char_t         cur_code;
    seg_t          cur_seg;

    assign slot_end    = (pcnt_q == PCNT_LAST);
    assign frame_start = (pcnt_q == '0) && (slot_q == 2'd3);
    assign frame_end   = slot_end && (slot_q == 2'd0);

    assign cur_code = char_at(frame_q.disp, slot_q);

    seg_decode u_dec (
        .code_i (cur_code),
        .seg_o  (cur_seg)
    );

    // Blink phase advances between frames so a digit never flickers mid-slot.
    always_comb begin
        pcnt_d   = slot_end ? '0 : pcnt_q + 1'b1;
        slot_d   = slot_end ? slot_q - 2'd1 : slot_q;
        fcnt_d   = fcnt_q;
        bphase_d = bphase_q;
        frame_d  = frame_q;
        if (frame_end) begin
            if (fcnt_q == FCNT_LAST) begin
                fcnt_d   = '0;
                bphase_d = ~bphase_q;
            end else begin
                fcnt_d = fcnt_q + 1'b1;
            end
        end
        if (frame_start) begin
            frame_d = '{disp: disp, blink: blink, dp: dp_in};
        end
    end

    always_comb begin
        en     = (pcnt_q >= DEAD_C) && !(bphase_q && frame_q.blink[slot_q]);
        an_d   = en ? ~(4'b0001 << slot_q) : 4'b1111;
        seg_d  = en ? cur_seg : SEG_OFF;
        dp_d   = en ? ~frame_q.dp[slot_q] : 1'b1;
        tick_d = frame_start;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pcnt_q     <= '0;
            slot_q     <= 2'd3;
            fcnt_q     <= '0;
            bphase_q   <= 1'b0;
            frame_q    <= FRAME_RST;
            an         <= 4'b1111;
            seg        <= SEG_OFF;
            dp         <= 1'b1;
            frame_tick <= 1'b0;
        end else begin
            pcnt_q     <= pcnt_d;
            slot_q     <= slot_d;
            fcnt_q     <= fcnt_d;
            bphase_q   <= bphase_d;
            frame_q    <= frame_d;
            an         <= an_d;
            seg        <= seg_d;
            dp         <= dp_d;
            frame_tick <= tick_d;
        end
    end

endmodule

// File: tb/tb_seg_scan.sv
// Scoreboard bench for seg_scan with DIV=8, DEAD=2, BLINK_DIV=2.
module tb_seg_scan;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [19:0] disp;
    logic [3:0]  blink;
    logic [3:0]  dp_in;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        frame_tick;

    seg_scan #(.DIV(8), .DEAD(2), .BLINK_DIV(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .disp       (disp),
        .blink      (blink),
        .dp_in      (dp_in),
        .an         (an),
        .seg        (seg),
        .dp         (dp),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
    } exp_t;

    exp_t expq[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc;
    int   slot_no = 0;

    always @(posedge clk or negedge rst) begin
        if (!rst) cyc <= 0;
        else      cyc <= cyc + 1;
    end

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic push(input logic [3:0] a, input logic [6:0] s, input logic d);
        expq.push_back('{an: a, seg: s, dp: d});
    endtask

    // Edge n after release shows counter state n-1: phase p = (n-1) mod 32, pcnt = p mod 8.
    int   p_m;
    exp_t e_m;
    always @(negedge clk) begin
        if (rst && cyc >= 1) begin
            p_m = (cyc - 1) % 32;
            check("frame_tick", {15'd0, frame_tick}, {15'd0, p_m == 0});
            check("an_onehot", {15'd0, $countones(~an) <= 1}, 16'd1);
            if (p_m % 8 < 2) begin
                check("an_dead", {12'd0, an}, 16'h000F);
                check("dp_dead", {15'd0, dp}, 16'd1);
            end
            if (p_m % 8 == 4 && expq.size() > 0) begin
                e_m = expq.pop_front();
                check($sformatf("an_slot%0d", slot_no), {12'd0, an}, {12'd0, e_m.an});
                check($sformatf("seg_slot%0d", slot_no), {9'd0, seg}, {9'd0, e_m.seg});
                check($sformatf("dp_slot%0d", slot_no), {15'd0, dp}, {15'd0, e_m.dp});
                slot_no++;
            end
        end
    end

    task automatic wait_neg(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation did not complete, required completion before %0t", $time);
        $fatal(1);
    end

    initial begin
        disp  = {5'd1, 5'd2, 5'd3, 5'd4};
        blink = 4'b0001;
        dp_in = 4'b0000;
        rst   = 1'b0;
        #12;
        check("rst_an", {12'd0, an}, 16'h000F);
        check("rst_seg", {9'd0, seg}, 16'h007F);
        check("rst_dp", {15'd0, dp}, 16'd1);
        check("rst_tick", {15'd0, frame_tick}, 16'd0);

        // frame 0: 1 2 3 4
        push(4'b0111, 7'b1111001, 1'b1);
        push(4'b1011, 7'b0100100, 1'b1);
        push(4'b1101, 7'b0110000, 1'b1);
        push(4'b1110, 7'b0011001, 1'b1);
        // frame 1: blank E r r, dp_in change still pending
        push(4'b0111, 7'h7F,      1'b1);
        push(4'b1011, 7'b0000110, 1'b1);
        push(4'b1101, 7'b0101111, 1'b1);
        push(4'b1110, 7'b0101111, 1'b1);
        // frames 2,3: digit 0 blinked off, dp on digit 2
        for (int f = 0; f < 2; f++) begin
            push(4'b0111, 7'h7F,      1'b1);
            push(4'b1011, 7'b0000110, 1'b0);
            push(4'b1101, 7'b0101111, 1'b1);
            push(4'b1111, 7'h7F,      1'b1);
        end
        // frames 4,5: digit 0 back on
        for (int f = 0; f < 2; f++) begin
            push(4'b0111, 7'h7F,      1'b1);
            push(4'b1011, 7'b0000110, 1'b0);
            push(4'b1101, 7'b0101111, 1'b1);
            push(4'b1110, 7'b0101111, 1'b1);
        end
        // frame 6: only the leftmost slot completes before reset
        push(4'b0111, 7'h7F, 1'b1);

        @(negedge clk);
        #2 rst = 1'b1;
        wait_neg(12);
        disp = {5'd31, 5'd14, 5'd25, 5'd25};
        wait_neg(28);
        dp_in = 4'b0100;
        wait_neg(164);
        check("pre_drop_an", {12'd0, an}, 16'h000B);
        #2 rst = 1'b0;
        #1;
        check("drop_an", {12'd0, an}, 16'h000F);
        check("drop_seg", {9'd0, seg}, 16'h007F);
        check("drop_dp", {15'd0, dp}, 16'd1);
        check("drop_tick", {15'd0, frame_tick}, 16'd0);
        check("queue_drained_1", expq.size(), 16'd0);

        disp  = {5'd0, 5'd8, 5'd10, 5'd23};
        blink = 4'b0000;
        dp_in = 4'b1000;
        for (int f = 0; f < 2; f++) begin
            push(4'b0111, 7'b1000000, 1'b0);
            push(4'b1011, 7'b0000000, 1'b1);
            push(4'b1101, 7'b0001000, 1'b1);
            push(4'b1110, 7'b1110111, 1'b1);
        end
        // frame 2: H L P n
        push(4'b0111, 7'b0001001, 1'b0);
        push(4'b1011, 7'b1000111, 1'b1);
        push(4'b1101, 7'b0001100, 1'b1);
        push(4'b1110, 7'b0101011, 1'b1);
        // frame 3: reserved o U y
        push(4'b0111, 7'h7F,      1'b0);
        push(4'b1011, 7'b0100011, 1'b1);
        push(4'b1101, 7'b1000001, 1'b1);
        push(4'b1110, 7'b0010001, 1'b1);

        #20;
        @(negedge clk);
        #2 rst = 1'b1;
        wait_neg(40);
        disp = {5'd16, 5'd17, 5'd18, 5'd19};
        wait_neg(32);
        disp = {5'd27, 5'd20, 5'd21, 5'd26};
        wait_neg(64);
        check("queue_drained_2", expq.size(), 16'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
